// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with an optional reduction mode.
//
// Each accepted beat computes F(x, b) for the 3-bit opcode in op:
//   0:~x  1:x&b  2:x|b  3:~(x&b)  4:~(x|b)  5:x^b  6:~(x^b)  7:x
// In IDLE, x is a. A beat with acc_en=1 and in_last=0 starts a reduction burst.
// During the burst, x is the running accumulator and a is ignored. The burst
// result is emitted on the beat that has in_last=1.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   input beat handshake (in_ready = !out_valid || out_ready)
//   a, b, op            operands and per-beat opcode
//   acc_en, in_last     burst start (sampled in IDLE only) and final-beat marker
//   out_valid/out_ready result handshake
//   y, out_beats        registered result and number of beats folded into it
//   popcnt              count of ones in y (only with LOGIC_UNIT_PIPE_POPCOUNT_EN)
//
// Optional feature macro: LOGIC_UNIT_PIPE_POPCOUNT_EN
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [7:0]       out_beats
`ifdef LOGIC_UNIT_PIPE_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [7:0]       r_count;
    logic [7:0]       w_count_nxt;
    logic [7:0]       w_count_inc;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] r_y;
    logic [7:0]       r_beats;

    logic             w_accept;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_f;
    logic             w_load;
    logic [7:0]       w_load_beats;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign out_beats = r_beats;

    // Saturating beat counter increment.
    assign w_count_inc = (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;

    // During a burst the accumulator replaces a as the left operand.
    assign w_x = (r_state == StAcc) ? r_acc : a;

    always_comb begin
        w_f = w_x;
        unique case (op)
            3'd0:    w_f = ~w_x;
            3'd1:    w_f = w_x & b;
            3'd2:    w_f = w_x | b;
            3'd3:    w_f = ~(w_x & b);
            3'd4:    w_f = ~(w_x | b);
            3'd5:    w_f = w_x ^ b;
            3'd6:    w_f = ~(w_x ^ b);
            default: w_f = w_x;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_count_nxt  = r_count;
        w_load       = 1'b0;
        w_load_beats = 8'd1;
        if (w_accept) begin
            unique case (r_state)
                StIdle: begin
                    if (acc_en && !in_last) begin
                        w_acc_nxt   = w_f;
                        w_count_nxt = 8'd1;
                        w_state_nxt = StAcc;
                    end else begin
                        w_load       = 1'b1;
                        w_load_beats = 8'd1;
                    end
                end
                StAcc: begin
                    if (!in_last) begin
                        w_acc_nxt   = w_f;
                        w_count_nxt = w_count_inc;
                    end else begin
                        w_load       = 1'b1;
                        w_load_beats = w_count_inc;
                        w_state_nxt  = StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // A load in the same cycle as a drain keeps out_valid high (no bubble).
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        if (w_load) begin
            w_out_valid_nxt = 1'b1;
        end else if (out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_count     <= 8'd0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_beats     <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_load) begin
                r_y     <= w_f;
                r_beats <= w_load_beats;
            end
        end
    end

`ifdef LOGIC_UNIT_PIPE_POPCOUNT_EN
    localparam int unsigned PCW = $clog2(WIDTH + 1);

    logic [PCW-1:0] r_popcnt;
    logic [PCW-1:0] w_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_popcnt = w_popcnt + PCW'(w_f[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_popcnt <= '0;
        end else if (w_load) begin
            r_popcnt <= w_popcnt;
        end
    end

    assign popcnt = r_popcnt;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc_en;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [7:0]   out_beats;
`ifdef LOGIC_UNIT_PIPE_POPCOUNT_EN
    logic [$clog2(W+1)-1:0] popcnt;
`endif

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_en    (acc_en),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_beats (out_beats)
`ifdef LOGIC_UNIT_PIPE_POPCOUNT_EN
        ,
        .popcnt    (popcnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: burst flag, accumulator, unsaturated beat tally, output holder.
    bit           m_burst;
    logic [W-1:0] m_acc;
    int           m_cnt;
    bit           m_ov;
    logic [W-1:0] m_y;
    int           m_beats;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [W-1:0] f_ref(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] z);
        case (o)
            3'd0: return ~x;
            3'd1: return x & z;
            3'd2: return x | z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return x ^ z;
            3'd6: return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic tick();
        bit           m_rdy;
        bit           load;
        logic [W-1:0] r;
        #1;
        m_rdy = !m_ov || out_ready;
        chk("in_ready", in_ready, m_rdy);
        load = 0;
        if (in_valid && m_rdy) begin
            if (!m_burst) begin
                r = f_ref(op, a, b);
                if (acc_en && !in_last) begin
                    m_burst = 1;
                    m_acc   = r;
                    m_cnt   = 1;
                end else begin
                    load    = 1;
                    m_y     = r;
                    m_beats = 1;
                end
            end else begin
                r = f_ref(op, m_acc, b);
                m_cnt++;
                if (!in_last) begin
                    m_acc = r;
                end else begin
                    load    = 1;
                    m_y     = r;
                    m_beats = (m_cnt > 255) ? 255 : m_cnt;
                    m_burst = 0;
                end
            end
        end
        if (load) m_ov = 1;
        else if (out_ready) m_ov = 0;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("y", y, m_y);
        chk("out_beats", out_beats, m_beats);
`ifdef LOGIC_UNIT_PIPE_POPCOUNT_EN
        chk("popcnt", popcnt, ones(m_y));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_burst = 0;
        m_acc   = '0;
        m_cnt   = 0;
        m_ov    = 0;
        m_y     = '0;
        m_beats = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_out_beats", out_beats, 0);
`ifdef LOGIC_UNIT_PIPE_POPCOUNT_EN
        chk("rst_popcnt", popcnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_or;
        logic [W-1:0] held;

        vecs[0] = '{3'd0, 8'hF0, 8'h3C, 8'h0F};
        vecs[1] = '{3'd1, 8'hF0, 8'h3C, 8'h30};
        vecs[2] = '{3'd2, 8'hF0, 8'h3C, 8'hFC};
        vecs[3] = '{3'd3, 8'hF0, 8'h3C, 8'hCF};
        vecs[4] = '{3'd4, 8'hF0, 8'h3C, 8'h03};
        vecs[5] = '{3'd5, 8'hF0, 8'h3C, 8'hCC};
        vecs[6] = '{3'd6, 8'hF0, 8'h3C, 8'h33};
        vecs[7] = '{3'd7, 8'hF0, 8'h3C, 8'hF0};

        in_valid  = 0;
        a         = '0;
        b         = '0;
        op        = '0;
        acc_en    = 0;
        in_last   = 0;
        out_ready = 1;
        do_reset();

        // Opcode table, one beat each, 1-cycle latency.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; acc_en = 0; in_last = 0; out_ready = 1;
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            tick();
            chk("vec_y", y, vecs[i].y);
            chk("vec_beats", out_beats, 1);
            chk("vec_valid", out_valid, 1);
`ifdef LOGIC_UNIT_PIPE_POPCOUNT_EN
            if (vecs[i].y == 8'hCC) chk("popcnt_cc", popcnt, 4);
`endif
        end
        in_valid = 0;
        tick();

        // XOR burst: 0^1^2^4 = 7 over 3 beats; a and acc_en ignored mid-burst.
        in_valid = 1; acc_en = 1; in_last = 0; op = 3'd5; a = 8'h00; b = 8'h01;
        tick();
        chk("burst_no_out1", out_valid, 0);
        acc_en = 0; a = 8'hAA; b = 8'h02;
        tick();
        chk("burst_no_out2", out_valid, 0);
        in_last = 1; b = 8'h04;
        tick();
        chk("burst_y", y, 8'h07);
        chk("burst_beats", out_beats, 3);
        in_valid = 0; in_last = 0;
        tick();

        // Backpressure: hold a result for 5 cycles, then drain and load together.
        in_valid = 1; acc_en = 0; op = 3'd7; a = 8'h5A; out_ready = 0;
        tick();
        held = y;
        chk("bp_loaded", held, 8'h5A);
        a = 8'h11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_y_stable", y, held);
        end
        out_ready = 1; a = 8'h22;
        tick();
        chk("bp_b2b_valid", out_valid, 1);
        chk("bp_b2b_y", y, 8'h22);
        in_valid = 0;
        tick();

        // 300-beat OR burst: count saturates at 255.
        exp_or = '0;
        in_valid = 1; acc_en = 1; op = 3'd2; out_ready = 1;
        for (int i = 0; i < 300; i++) begin
            a = (i == 0) ? 8'h00 : W'($urandom);
            b = (i == 137) ? 8'h80 : (W'($urandom) & 8'h0F);
            exp_or = exp_or | b;
            in_last = (i == 299);
            tick();
        end
        chk("sat_y", y, exp_or);
        chk("sat_beats", out_beats, 255);
        in_valid = 0; in_last = 0; acc_en = 0;
        tick();

        // Reset mid-burst discards the partial reduction.
        in_valid = 1; acc_en = 1; in_last = 0; op = 3'd1; a = 8'hFF; b = 8'hF0;
        tick();
        b = 8'h0F;
        tick();
        in_valid = 0;
        do_reset();
        chk("mid_rst_valid", out_valid, 0);
        in_valid = 1; acc_en = 0; op = 3'd1; a = 8'hFF; b = 8'h55;
        tick();
        chk("post_rst_y", y, 8'h55);
        chk("post_rst_beats", out_beats, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            acc_en    = ($urandom_range(0, 1) != 0);
            in_last   = ($urandom_range(0, 3) == 0);
            op        = 3'($urandom_range(0, 7));
            a         = W'($urandom);
            b         = W'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
